// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: data width, memory operations and data-memory arbiter types.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    LB, LH, LW, LBU, LHU, SB, SH, SW
  } operation_e;

  localparam operation_e OP_DEFAULT = LW;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCK
  } arb_state_e;

  typedef enum logic {
    REQ_CORE,
    REQ_DMA
  } requester_e;

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating wait counter with synchronous clear; max_o flags count == MAX.
module dmem_arb_starve_cnt #(
  parameter int unsigned MAX = 8
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic max_o
);

  localparam int unsigned W = $clog2(MAX + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != W'(MAX)))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign max_o = (cnt_q == W'(MAX));

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between core MEM stage and DMA, round-robin with DMA lock.
// Optional core starvation guard: DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            core_req_i,
  input  logic            core_we_i,
  input  logic [XLEN-1:0] core_addr_i,
  input  logic [XLEN-1:0] core_wdata_i,
  input  operation_e      core_op_i,
  output logic            core_gnt_o,
  output logic            core_stall_o,
  output logic            core_rvalid_o,
  output logic [XLEN-1:0] core_rdata_o,
  input  logic            dma_req_i,
  input  logic            dma_we_i,
  input  logic [XLEN-1:0] dma_addr_i,
  input  logic [XLEN-1:0] dma_wdata_i,
  input  operation_e      dma_op_i,
  input  logic            dma_lock_i,
  output logic            dma_gnt_o,
  output logic            dma_rvalid_o,
  output logic [XLEN-1:0] dma_rdata_o,
  output logic            mem_write_enable_o,
  output logic            mem_read_enable_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output operation_e      mem_op_o,
  input  logic [XLEN-1:0] mem_rdata_i
);

  arb_state_e      state_q, state_d;
  requester_e      last_q, last_d;
  logic            starve;
  logic            core_rvalid_q, dma_rvalid_q;
  logic [XLEN-1:0] core_rdata_q, dma_rdata_q;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  logic wait_max;

  dmem_arb_starve_cnt #(
    .MAX (MAX_WAIT)
  ) u_starve_cnt (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .inc_i  (core_stall_o),
    .clr_i  (core_gnt_o),
    .max_o  (wait_max)
  );

  assign starve = core_req_i & wait_max;
`else
  assign starve = 1'b0 & (MAX_WAIT == 0);
`endif

  always_comb begin
    core_gnt_o = 1'b0;
    dma_gnt_o  = 1'b0;
    state_d    = state_q;
    last_d     = last_q;

    if (starve)
      core_gnt_o = 1'b1;
    else if (state_q == ARB_LOCK)
      dma_gnt_o = dma_req_i;
    else if (core_req_i && dma_req_i) begin
      core_gnt_o = (last_q == REQ_DMA);
      dma_gnt_o  = (last_q == REQ_CORE);
    end else begin
      core_gnt_o = core_req_i;
      dma_gnt_o  = dma_req_i;
    end

    if (core_gnt_o)     last_d = REQ_CORE;
    else if (dma_gnt_o) last_d = REQ_DMA;

    case (state_q)
      ARB_IDLE: if (dma_gnt_o && dma_lock_i) state_d = ARB_LOCK;
      ARB_LOCK: if (starve || !dma_req_i || (dma_gnt_o && !dma_lock_i)) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  assign core_stall_o = core_req_i & ~core_gnt_o;

  always_comb begin
    mem_write_enable_o = 1'b0;
    mem_read_enable_o  = 1'b0;
    mem_addr_o         = '0;
    mem_wdata_o        = '0;
    mem_op_o           = OP_DEFAULT;
    if (core_gnt_o) begin
      mem_write_enable_o = core_we_i;
      mem_read_enable_o  = ~core_we_i;
      mem_addr_o         = core_addr_i;
      mem_wdata_o        = core_wdata_i;
      mem_op_o           = core_op_i;
    end else if (dma_gnt_o) begin
      mem_write_enable_o = dma_we_i;
      mem_read_enable_o  = ~dma_we_i;
      mem_addr_o         = dma_addr_i;
      mem_wdata_o        = dma_wdata_i;
      mem_op_o           = dma_op_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= ARB_IDLE;
      last_q        <= REQ_DMA;
      core_rvalid_q <= 1'b0;
      dma_rvalid_q  <= 1'b0;
      core_rdata_q  <= '0;
      dma_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      core_rvalid_q <= core_gnt_o & ~core_we_i;
      dma_rvalid_q  <= dma_gnt_o & ~dma_we_i;
      if (core_gnt_o && !core_we_i) core_rdata_q <= mem_rdata_i;
      if (dma_gnt_o && !dma_we_i)   dma_rdata_q  <= mem_rdata_i;
    end
  end

  assign core_rvalid_o = core_rvalid_q;
  assign core_rdata_o  = core_rdata_q;
  assign dma_rvalid_o  = dma_rvalid_q;
  assign dma_rdata_o   = dma_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: random traffic against a behavioural arbiter/memory model.
module tb_dmem_arbiter;
  import riscv_pkg::*;

  localparam int unsigned MAXW = 8;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        core_req_i = 1'b0, core_we_i = 1'b0;
  logic [31:0] core_addr_i = '0, core_wdata_i = '0;
  operation_e  core_op_i = LW;
  logic        dma_req_i = 1'b0, dma_we_i = 1'b0, dma_lock_i = 1'b0;
  logic [31:0] dma_addr_i = '0, dma_wdata_i = '0;
  operation_e  dma_op_i = LW;
  logic        core_gnt_o, core_stall_o, core_rvalid_o, dma_gnt_o, dma_rvalid_o;
  logic [31:0] core_rdata_o, dma_rdata_o;
  logic        mem_write_enable_o, mem_read_enable_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  operation_e  mem_op_o;

  always #5 clk_i = ~clk_i;

  dmem_arbiter #(.MAX_WAIT(MAXW)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i),
    .core_wdata_i(core_wdata_i), .core_op_i(core_op_i), .core_gnt_o(core_gnt_o),
    .core_stall_o(core_stall_o), .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .dma_req_i(dma_req_i), .dma_we_i(dma_we_i), .dma_addr_i(dma_addr_i),
    .dma_wdata_i(dma_wdata_i), .dma_op_i(dma_op_i), .dma_lock_i(dma_lock_i),
    .dma_gnt_o(dma_gnt_o), .dma_rvalid_o(dma_rvalid_o), .dma_rdata_o(dma_rdata_o),
    .mem_write_enable_o(mem_write_enable_o), .mem_read_enable_o(mem_read_enable_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_op_o(mem_op_o),
    .mem_rdata_i(mem_rdata_i)
  );

  function automatic logic [31:0] init_word(int unsigned i);
    return 32'h9E3779B9 * 32'(i + 1);
  endfunction

  function automatic logic [31:0] load_fmt(logic [31:0] w, operation_e op, logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (op)
      LB:      return {{24{b[7]}}, b};
      LBU:     return {24'b0, b};
      LH:      return {{16{h[15]}}, h};
      LHU:     return {16'b0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(logic [31:0] w, operation_e op, logic [1:0] off,
                                              logic [31:0] d);
    logic [31:0] r;
    r = w;
    case (op)
      SB:      r[{off, 3'b000} +: 8] = d[7:0];
      SH:      if (off[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  // memory environment seen by the DUT
  logic [31:0] mem [64];
  initial for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
  always_comb mem_rdata_i = load_fmt(mem[mem_addr_o[7:2]], mem_op_o, mem_addr_o[1:0]);
  always @(posedge clk_i)
    if (mem_write_enable_o)
      mem[mem_addr_o[7:2]] <= store_merge(mem[mem_addr_o[7:2]], mem_op_o, mem_addr_o[1:0], mem_wdata_o);

  typedef struct packed {
    logic        cg;
    logic        dg;
    logic        stall;
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    operation_e  op;
    logic        crv;
    logic [31:0] crd;
    logic        drv;
    logic [31:0] drd;
  } snap_t;

  int unsigned vectors = 0, miscompares = 0;
  snap_t obs, exp_s;

  // reference model state
  logic [31:0] gmem [64];
  bit          m_lock, m_last_dma, m_crv, m_drv;
  logic [31:0] m_crd, m_drd;
  int unsigned m_wait;
  bit          e_cg, e_dg, e_we, e_starve;
  logic [31:0] e_addr, e_rd;
  operation_e  e_op;

  task automatic model_reset();
    m_lock = 0; m_last_dma = 1; m_wait = 0;
    m_crv = 0; m_drv = 0; m_crd = '0; m_drd = '0;
  endtask

  task automatic model_eval();
    e_starve = 0;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    e_starve = core_req_i && (m_wait == MAXW);
`endif
    e_cg = 0; e_dg = 0;
    if (e_starve) e_cg = 1;
    else if (m_lock) e_dg = dma_req_i;
    else if (core_req_i && dma_req_i) begin
      e_cg = m_last_dma; e_dg = !m_last_dma;
    end else begin
      e_cg = core_req_i; e_dg = dma_req_i;
    end
    exp_s = '0;
    exp_s.op = OP_DEFAULT;
    e_we = 0; e_addr = '0; e_op = OP_DEFAULT;
    if (e_cg) begin
      e_we = core_we_i; e_addr = core_addr_i; e_op = core_op_i;
      exp_s.wdata = core_wdata_i;
    end else if (e_dg) begin
      e_we = dma_we_i; e_addr = dma_addr_i; e_op = dma_op_i;
      exp_s.wdata = dma_wdata_i;
    end
    e_rd = load_fmt(gmem[e_addr[7:2]], e_op, e_addr[1:0]);
    exp_s.cg = e_cg; exp_s.dg = e_dg; exp_s.stall = core_req_i && !e_cg;
    exp_s.we = (e_cg || e_dg) && e_we;
    exp_s.re = (e_cg || e_dg) && !e_we;
    exp_s.addr = e_addr; exp_s.op = e_op;
    exp_s.crv = m_crv; exp_s.crd = m_crd; exp_s.drv = m_drv; exp_s.drd = m_drd;
    obs = '{core_gnt_o, dma_gnt_o, core_stall_o, mem_write_enable_o, mem_read_enable_o,
            mem_addr_o, mem_wdata_o, mem_op_o, core_rvalid_o, core_rdata_o,
            dma_rvalid_o, dma_rdata_o};
  endtask

  task automatic model_commit();
    if ((e_cg || e_dg) && e_we)
      gmem[e_addr[7:2]] = store_merge(gmem[e_addr[7:2]], e_op, e_addr[1:0], exp_s.wdata);
    m_crv = e_cg && !e_we;
    m_drv = e_dg && !e_we;
    if (m_crv) m_crd = e_rd;
    if (m_drv) m_drd = e_rd;
    if (!m_lock) begin
      if (e_dg && dma_lock_i) m_lock = 1;
    end else if (e_starve || !dma_req_i || (e_dg && !dma_lock_i))
      m_lock = 0;
    if (e_cg) m_last_dma = 0;
    else if (e_dg) m_last_dma = 1;
    if (e_cg) m_wait = 0;
    else if (core_req_i && m_wait < MAXW) m_wait++;
  endtask

  // inputs are set at a falling edge; sample mid-phase, advance one cycle
  task automatic tick();
    #2;
    model_eval();
    @(posedge clk_i);
    model_commit();
    @(negedge clk_i);
  endtask

  task automatic rand_req(output logic we, output logic [31:0] a, output logic [31:0] d,
                          output operation_e op);
    logic [2:0] k;
    k = 3'($urandom_range(7));
    op = operation_e'(k);
    we = (k >= 3'd5);
    a = {24'b0, 8'($urandom_range(255))};
    if (op == LW || op == SW) a[1:0] = 2'b00;
    else if (op == LH || op == LHU || op == SH) a[0] = 1'b0;
    d = $urandom;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rstn_i = 1'b0; core_req_i = 1'b0; dma_req_i = 1'b0; dma_lock_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    rstn_i = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    rstn_i = 1'b0; core_req_i = 1'b0; dma_req_i = 1'b0;
    #1;
    vectors++;
    if ({core_gnt_o, dma_gnt_o, mem_write_enable_o, mem_read_enable_o, mem_addr_o, mem_op_o,
         core_rvalid_o, core_rdata_o, dma_rvalid_o, dma_rdata_o} !==
        {4'b0000, 32'h0, OP_DEFAULT, 1'b0, 32'h0, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_state gnt=%b/%b en=%b/%b rv=%b/%b rd=%h/%h", core_gnt_o, dma_gnt_o,
               mem_write_enable_o, mem_read_enable_o, core_rvalid_o, dma_rvalid_o,
               core_rdata_o, dma_rdata_o);
    end
    model_reset();
    @(negedge clk_i);
    rstn_i = 1'b1;
  endtask

  task automatic test_core_load();
    core_req_i = 1; core_we_i = 0; core_addr_i = 32'h10; core_op_i = LW;
    tick();
    vectors++;
    if (obs !== exp_s || !obs.cg || !obs.re) begin
      miscompares++; $display("FAIL core_load_grant obs=%h exp=%h", obs, exp_s);
    end
    core_req_i = 0;
    tick();
    vectors++;
    if (obs !== exp_s || obs.crv !== 1'b1 || obs.crd !== init_word(4)) begin
      miscompares++; $display("FAIL core_load_resp obs=%h exp=%h", obs, exp_s);
    end
  endtask

  task automatic test_alternate();
    do_reset();
    rand_req(core_we_i, core_addr_i, core_wdata_i, core_op_i);
    rand_req(dma_we_i, dma_addr_i, dma_wdata_i, dma_op_i);
    core_req_i = 1; dma_req_i = 1; dma_lock_i = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      vectors++;
      if (obs !== exp_s || obs.cg !== (i % 2 == 0) || obs.stall !== (i % 2 == 1)) begin
        miscompares++; $display("FAIL alternate cyc=%0d obs=%h exp=%h", i, obs, exp_s);
      end
      if (e_cg) rand_req(core_we_i, core_addr_i, core_wdata_i, core_op_i);
      if (e_dg) rand_req(dma_we_i, dma_addr_i, dma_wdata_i, dma_op_i);
    end
    core_req_i = 0; dma_req_i = 0;
  endtask

  task automatic test_lock();
    int unsigned beats = 0, stalls = 0;
    do_reset();
    rand_req(core_we_i, core_addr_i, core_wdata_i, core_op_i);
    core_req_i = 1;
    dma_we_i = 1; dma_op_i = SW; dma_addr_i = 32'h20;
    for (int i = 0; i < 8; i++) begin
      dma_req_i = (beats < 4); dma_lock_i = (beats < 3); dma_wdata_i = 32'hD0A0_0000 + beats;
      tick();
      vectors++;
      if (obs !== exp_s) begin
        miscompares++; $display("FAIL lock cyc=%0d obs=%h exp=%h", i, obs, exp_s);
      end
      if (obs.dg) beats++;
      if (obs.stall) stalls++;
      if (e_cg) rand_req(core_we_i, core_addr_i, core_wdata_i, core_op_i);
    end
    vectors++;
    if (stalls != 4 || beats != 4) begin
      miscompares++; $display("FAIL lock_counts stalls=%0d beats=%0d want 4/4", stalls, beats);
    end
    core_req_i = 0; dma_req_i = 0; dma_lock_i = 0;
  endtask

  task automatic test_starve();
    int unsigned beats = 0, stalls = 0, first = 0;
    bit seen = 0;
    int unsigned want;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    want = MAXW;
`else
    want = 19;
`endif
    do_reset();
    dma_we_i = 0; dma_op_i = LW; dma_addr_i = 32'h40;
    for (int i = 0; i < 40; i++) begin
      if (i == 1) begin
        core_req_i = 1; rand_req(core_we_i, core_addr_i, core_wdata_i, core_op_i);
      end
      dma_req_i = (beats < 20); dma_lock_i = (beats < 19);
      tick();
      vectors++;
      if (obs !== exp_s) begin
        miscompares++; $display("FAIL starve cyc=%0d obs=%h exp=%h", i, obs, exp_s);
      end
      if (obs.dg) beats++;
      if (obs.stall) stalls++;
      if (obs.cg && !seen) begin seen = 1; first = stalls; end
      if (e_cg) rand_req(core_we_i, core_addr_i, core_wdata_i, core_op_i);
      if (e_dg) dma_addr_i = dma_addr_i + 4;
    end
    vectors++;
    if (!seen || first != want || beats != 20) begin
      miscompares++;
      $display("FAIL starve_first seen=%0d stalls=%0d want %0d beats=%0d", seen, first, want, beats);
    end
    core_req_i = 0; dma_req_i = 0; dma_lock_i = 0;
  endtask

  task automatic test_sb_lbu();
    tick();
    core_req_i = 1; core_we_i = 1; core_op_i = SB; core_addr_i = 32'h30;
    core_wdata_i = 32'h1234_56A5;
    tick();
    vectors++;
    if (obs !== exp_s || !obs.cg || !obs.we) begin
      miscompares++; $display("FAIL sb_grant obs=%h exp=%h", obs, exp_s);
    end
    core_we_i = 0; core_op_i = LBU;
    tick();
    vectors++;
    if (obs !== exp_s || !obs.cg || !obs.re) begin
      miscompares++; $display("FAIL lbu_grant obs=%h exp=%h", obs, exp_s);
    end
    core_req_i = 0;
    tick();
    vectors++;
    if (obs !== exp_s || obs.crv !== 1'b1 || obs.crd !== 32'h0000_00A5) begin
      miscompares++; $display("FAIL lbu_data obs=%h exp=%h", obs, exp_s);
    end
  endtask

  task automatic test_reset_midread();
    core_req_i = 1; core_we_i = 0; core_addr_i = 32'h10; core_op_i = LW;
    tick();
    core_req_i = 0;
    vectors++;
    if (core_rvalid_o !== 1'b1) begin
      miscompares++; $display("FAIL midread_pre rvalid=%b want 1", core_rvalid_o);
    end
    rstn_i = 1'b0;
    #1;
    vectors++;
    if (core_rvalid_o !== 1'b0 || core_rdata_o !== 32'h0) begin
      miscompares++;
      $display("FAIL midread_reset rvalid=%b rdata=%h want 0/0", core_rvalid_o, core_rdata_o);
    end
    model_reset();
    @(negedge clk_i);
    rstn_i = 1'b1;
    rand_req(core_we_i, core_addr_i, core_wdata_i, core_op_i);
    rand_req(dma_we_i, dma_addr_i, dma_wdata_i, dma_op_i);
    core_req_i = 1; dma_req_i = 1; dma_lock_i = 0;
    tick();
    vectors++;
    if (obs !== exp_s || !obs.cg || obs.dg) begin
      miscompares++; $display("FAIL midread_tie obs=%h exp=%h", obs, exp_s);
    end
    core_req_i = 0; dma_req_i = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if (!core_req_i && $urandom_range(1) == 1) begin
        core_req_i = 1; rand_req(core_we_i, core_addr_i, core_wdata_i, core_op_i);
      end
      if (!dma_req_i) begin
        dma_lock_i = 0;
        if ($urandom_range(2) == 0) begin
          dma_req_i = 1; dma_lock_i = ($urandom_range(1) == 1);
          rand_req(dma_we_i, dma_addr_i, dma_wdata_i, dma_op_i);
        end
      end
      tick();
      vectors++;
      if (obs !== exp_s) begin
        miscompares++; $display("FAIL random cyc=%0d obs=%h exp=%h", i, obs, exp_s);
      end
      if (e_cg) core_req_i = 0;
      if (e_dg) begin
        dma_req_i = ($urandom_range(1) == 1);
        if (dma_req_i) rand_req(dma_we_i, dma_addr_i, dma_wdata_i, dma_op_i);
        dma_lock_i = dma_req_i && ($urandom_range(1) == 1);
      end
    end
    core_req_i = 0; dma_req_i = 0; dma_lock_i = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) gmem[i] = init_word(i);
    model_reset();
    test_reset();
    test_core_load();
    test_alternate();
    test_lock();
    test_starve();
    test_sb_lbu();
    test_reset_midread();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data memory port between the core's MEM stage and a DMA/loader requester. Grants are zero-cycle, using round-robin with an optional DMA lock. Read responses are registered and returned one cycle after the grant. Sits between the execute/memory pipeline boundary and the data memory block; drives the memory's write/read enable, address, data and operation inputs.

## Interface
- XLEN, 32 (from riscv_pkg): data/address width
- MAX_WAIT, 8: core starvation limit in cycles (used only with guard enabled)
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- core_req_i  in  1  core access request
- core_we_i  in  1  1 = store, 0 = load
- core_addr_i  in  XLEN  byte address
- core_wdata_i  in  XLEN  store data
- core_op_i  in  operation_e  LB/LH/LW/LBU/LHU/SB/SH/SW
- core_gnt_o  out  1  core request accepted this cycle
- core_stall_o  out  1  core_req_i & ~core_gnt_o
- core_rvalid_o  out  1  core read data valid
- core_rdata_o  out  XLEN  core read data
- dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i, dma_op_i  in  1/1/XLEN/XLEN/operation_e  DMA request, same meaning as core
- dma_lock_i  in  1  hold grant for following DMA beats
- dma_gnt_o, dma_rvalid_o, dma_rdata_o  out  1/1/XLEN  DMA grant/response
- mem_write_enable_o, mem_read_enable_o  out  1  memory enables
- mem_addr_o  out  XLEN  drives both memory read and write address
- mem_wdata_o  out  XLEN  store data
- mem_op_o  out  operation_e  access type
- mem_rdata_i  in  XLEN  combinational memory read data

## Operation
- States:
  - ARB_IDLE: round-robin arbitration.
  - ARB_LOCK: only DMA may be granted.
- Grant rules in ARB_IDLE:
  - One requester active: it is granted.
  - Both active: the requester not granted last wins.
  - last_grant resets to DMA, so the core wins the first tie.
- A granted request is forwarded combinationally to the mem_* outputs.
  - we=1 drives mem_write_enable_o; we=0 drives mem_read_enable_o; never both.
  - No grant: enables 0, mem_addr_o/mem_wdata_o 0, mem_op_o = default op.
- Lock entry: DMA granted with dma_lock_i=1 moves ARB_IDLE to ARB_LOCK.
- Lock exit to ARB_IDLE, on any of:
  - a granted DMA beat with dma_lock_i=0;
  - dma_req_i=0;
  - a starvation override (guard enabled).
- Read response:
  - Granted read: rdata register captures mem_rdata_i at the clock edge.
  - The owner's rvalid is set for exactly the next cycle.
  - The other requester's rvalid stays 0; its rdata holds its last value.
- Back-to-back reads are permitted; one response per cycle.
- Reset (asynchronous, any time):
  - state ARB_IDLE, last_grant DMA, wait counter 0;
  - both rvalid 0, both rdata 0;
  - in-flight read response discarded.

## Timing
- Grant: combinational, same cycle as request. Store commits at that cycle's rising edge.
- Read latency: rvalid/rdata one cycle after grant.
- Requests must be held stable until granted; address/data may change after gnt.
- core_stall_o is combinational; the core pipeline freezes while it is high.
- ARB_LOCK entry/exit takes effect from the cycle after the deciding edge.

## Configuration
- DMEM_ARB_STARVE_GUARD_EN defined:
  - Counter increments each cycle with core_req_i & ~core_gnt_o and clears on core grant.
  - When count == MAX_WAIT, the core is granted unconditionally, ARB_LOCK is left, and the counter clears.
- Undefined: no counter; the lock is honoured indefinitely and the core may starve.

## Structure
- riscv_pkg gains arb_state_e {ARB_IDLE, ARB_LOCK} and requester_e {REQ_CORE, REQ_DMA}. It already provides operation_e and XLEN.
- One sub-module, dmem_arb_starve_cnt: a saturating wait counter with clear, instantiated only under DMEM_ARB_STARVE_GUARD_EN.

## Test plan
- Reset, then core LW 0x10 with no DMA -> core_gnt_o=1 same cycle, mem_read_enable_o=1, core_rvalid_o=1 next cycle with memory word.
- Both request continuously -> grants alternate core, DMA, core, DMA; core_stall_o high exactly on DMA cycles.
- DMA SW to 0x20 with dma_lock_i=1 for 4 beats while core requests -> DMA granted 4 cycles, then core granted; core_stall_o high for 4 cycles.
- With guard enabled, MAX_WAIT=8, DMA locked for 20 beats -> core granted on wait cycle 8, DMA resumes afterwards; without guard, core granted only after lock release.
- Core SB 0xA5 to 0x30 then LBU 0x30 back-to-back -> second grant next cycle, rdata=0x000000A5.
- rstn_i asserted in the cycle after a granted read -> rvalid forced 0 immediately, state ARB_IDLE, first tie after reset goes to core.
